// File: rtl/mod_arbiter_pkg.sv
// Shared definitions for the mod_arbiter block: FSM state encoding,
// default widths and the requester-ID width helper.
package mod_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int DW_DEF   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an index into NREQ requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_arbiter_rr_arbiter.sv
// Round-robin grant: the first asserted request strictly after last_grant
// wins, wrapping from NREQ-1 back to 0. Output is one-hot or all zero.
module rr_arbiter
  import mod_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]           req,
  input  logic [id_width(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]           grant
);

  localparam int IDW = id_width(NREQ);

  logic found;

  // Two passes: indices above last_grant first, then the wrapped-around
  // indices up to and including last_grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDW'(i) > last_grant)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDW'(i) <= last_grant)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_arbiter.sv
// mod_arbiter: NREQ requesters share one iterative modulo engine that
// performs one restoring subtraction per cycle (value mod div).
// Optional feature macro: MOD_ARBITER_QUOTIENT_EN adds the quotient counter;
// without it resp_quo is tied to zero and timing is identical.
module mod_arbiter
  import mod_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_value,
  input  logic [NREQ*DW-1:0]        req_div,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [id_width(NREQ)-1:0] resp_id,
  output logic [W-1:0]              resp_rem,
  output logic [W-1:0]              resp_quo,
  output logic                      resp_err
);

  localparam int IDW = id_width(NREQ);

  state_t         state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [DW-1:0]  div_q, div_d;
  logic           err_q, err_d;
`ifdef MOD_ARBITER_QUOTIENT_EN
  logic [W-1:0]   quo_q, quo_d;
`endif

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [W-1:0]    sel_value;
  logic [DW-1:0]   sel_div;
  logic [W-1:0]    div_ext;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Grants are only offered while idle; reset masks them immediately.
  assign req_ready = (state_q == IDLE && !reset) ? grant : '0;

  // Divisor is zero-extended so the compare and subtract are unsigned W-bit.
  assign div_ext = W'(div_q);

  // Steer the winning requester's operands and index.
  always_comb begin
    grant_idx = '0;
    sel_value = '0;
    sel_div   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx = IDW'(i);
        sel_value = req_value[i*W +: W];
        sel_div   = req_div[i*DW +: DW];
      end
    end
  end

  // Next-state and datapath: accept, subtract loop, hold result until taken.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    acc_d        = acc_q;
    div_d        = div_q;
    err_d        = err_q;
`ifdef MOD_ARBITER_QUOTIENT_EN
    quo_d        = quo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d      = ITER;
          last_grant_d = grant_idx;
          id_d         = grant_idx;
          acc_d        = sel_value;
          div_d        = sel_div;
          err_d        = 1'b0;
`ifdef MOD_ARBITER_QUOTIENT_EN
          quo_d        = '0;
`endif
        end
      end
      ITER: begin
        // A zero divisor must be caught first: acc >= 0 is always true.
        if (div_q == '0) begin
          state_d = DONE;
          err_d   = 1'b1;
`ifdef MOD_ARBITER_QUOTIENT_EN
          quo_d   = '1;
`endif
        end else if (acc_q >= div_ext) begin
          acc_d = acc_q - div_ext;
`ifdef MOD_ARBITER_QUOTIENT_EN
          quo_d = quo_q + W'(1);
`endif
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      acc_q        <= '0;
      div_q        <= '0;
      err_q        <= 1'b0;
`ifdef MOD_ARBITER_QUOTIENT_EN
      quo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      acc_q        <= acc_d;
      div_q        <= div_d;
      err_q        <= err_d;
`ifdef MOD_ARBITER_QUOTIENT_EN
      quo_q        <= quo_d;
`endif
    end
  end

  assign resp_valid = (state_q == DONE);
  assign resp_id    = id_q;
  assign resp_rem   = acc_q;
  assign resp_err   = err_q;
`ifdef MOD_ARBITER_QUOTIENT_EN
  assign resp_quo   = quo_q;
`else
  assign resp_quo   = '0;
`endif

endmodule

// File: tb/tb_mod_arbiter.sv
// Scoreboard bench for mod_arbiter: a reference model predicts grants and
// responses from plain arithmetic; a monitor pops and compares responses.
`timescale 1ns/1ps
module tb_mod_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int DW   = 5;
  localparam int IDW  = 2;
  localparam int QMAX = (1 << W) - 1;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*W-1:0]     req_value = '0;
  logic [NREQ*DW-1:0]    req_div = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b1;
  logic [IDW-1:0]        resp_id;
  logic [W-1:0]          resp_rem;
  logic [W-1:0]          resp_quo;
  logic                  resp_err;

  mod_arbiter #(.NREQ(NREQ), .W(W), .DW(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_value  (req_value),
    .req_div    (req_div),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_rem   (resp_rem),
    .resp_quo   (resp_quo),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int id;
    int rem;
    int quo;
    int err;
    int due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   busy = 0;
  bit   active = 0;
  int   last = NREQ - 1;
  bit   pend[NREQ];
  bit   accepted[NREQ];
  int   dut_grants[$];
  bit   log_grants = 0;

  int              m_win, m_best, m_dist, m_v, m_d;
  logic [NREQ-1:0] m_exp_ready;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: engine is busy from accept until the response handshake;
  // when free, the winner is the valid requester nearest after the last grant.
  always @(negedge clock) begin
    #1;
    if (reset) begin
      exp_q.delete();
      busy = 0;
      last = NREQ - 1;
      for (int i = 0; i < NREQ; i++) accepted[i] = 0;
      chk("ready_in_reset", req_ready, 0);
    end else begin
      m_win  = -1;
      m_best = NREQ;
      if (!busy) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i]) begin
            m_dist = (i - last - 1 + 2 * NREQ) % NREQ;
            if (m_dist < m_best) begin
              m_best = m_dist;
              m_win  = i;
            end
          end
        end
      end
      m_exp_ready = '0;
      if (m_win >= 0) m_exp_ready[m_win] = 1'b1;
      chk("req_ready", req_ready, m_exp_ready);
      chk("ready_onehot", $onehot0(req_ready), 1);
      if (log_grants && req_ready != '0)
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grants.push_back(i);
      if (m_win >= 0) begin
        m_v      = int'(req_value[m_win*W +: W]);
        m_d      = int'(req_div[m_win*DW +: DW]);
        m_e.id   = m_win;
        m_e.err  = (m_d == 0) ? 1 : 0;
        m_e.rem  = (m_d == 0) ? m_v : m_v % m_d;
`ifdef MOD_ARBITER_QUOTIENT_EN
        m_e.quo  = (m_d == 0) ? QMAX : m_v / m_d;
`else
        m_e.quo  = 0;
`endif
        m_e.due  = cyc + 1 + ((m_d == 0) ? 1 : m_v / m_d + 1);
        exp_q.push_back(m_e);
        busy = 1;
        last = m_win;
        accepted[m_win] = 1;
      end
    end
  end

  // Monitor: compares each presented response with the oldest expectation.
  always @(negedge clock) begin
    #2;
    if (reset) begin
      active = 0;
    end else if (!active && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", resp_valid, 0);
      end else begin
        cur    = exp_q.pop_front();
        active = 1;
        chk("resp_latency", cyc, cur.due);
        chk("resp_id", resp_id, cur.id);
        chk("resp_rem", resp_rem, cur.rem);
        chk("resp_quo", resp_quo, cur.quo);
        chk("resp_err", resp_err, cur.err);
      end
    end else if (active) begin
      chk("resp_hold_valid", resp_valid, 1);
      chk("resp_hold_id", resp_id, cur.id);
      chk("resp_hold_rem", resp_rem, cur.rem);
      chk("resp_hold_quo", resp_quo, cur.quo);
      chk("resp_hold_err", resp_err, cur.err);
      if (!resp_valid) begin
        active = 0;
        busy   = 0;
      end
    end else if (busy && exp_q.size() > 0 && cyc > exp_q[0].due) begin
      chk("resp_timeout", resp_valid, 1);
      exp_q.delete(0);
      busy = 0;
    end else if (!busy) begin
      chk("resp_idle", resp_valid, 0);
    end
    if (!reset && active && resp_valid && resp_ready) begin
      active = 0;
      busy   = 0;
    end
  end

  task automatic issue(input int i, input int v, input int d);
    pend[i] = 1;
    req_value[i*W +: W]   = W'(v);
    req_div[i*DW +: DW]   = DW'(d);
  endtask

  // One call drives n cycles; accepted requesters drop and scramble inputs.
  task automatic run(input int n, input int p_req, input int p_ready);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      for (int i = 0; i < NREQ; i++) begin
        if (accepted[i]) begin
          accepted[i] = 0;
          pend[i]     = 0;
          req_value[i*W +: W] = W'($urandom);
          req_div[i*DW +: DW] = DW'($urandom);
        end
        if (!pend[i] && ($urandom % 100) < p_req) begin
          pend[i] = 1;
          req_value[i*W +: W] = W'($urandom_range(0, 255));
          req_div[i*DW +: DW] = (($urandom % 8) == 0) ? '0 : DW'($urandom_range(1, 31));
        end
        req_valid[i] = pend[i];
      end
      resp_ready = (($urandom % 100) < p_ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i]     = 0;
      accepted[i] = 0;
    end
    @(negedge clock);
    #3;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_rem", resp_rem, 0);
    chk("rst_resp_quo", resp_quo, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    do_reset();

    // 23 mod 5 from requester 0
    issue(0, 23, 5);
    run(12, 0, 100);

    // zero divisor from requester 2
    issue(2, 200, 0);
    run(6, 0, 100);

    // result held while the consumer stalls
    issue(1, 9, 7);
    run(6, 0, 0);
    run(4, 0, 100);

    // all requesters hold valid continuously
    do_reset();
    dut_grants.delete();
    log_grants = 1;
    for (int i = 0; i < NREQ; i++) issue(i, $urandom_range(0, 60), $urandom_range(1, 31));
    for (int c = 0; c < 3000 && dut_grants.size() < 5; c++) run(1, 100, 100);
    log_grants = 0;
    chk("rr_grant_count", (dut_grants.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      if (k < dut_grants.size()) chk("rr_order", dut_grants[k], rr_exp[k]);
    run(1200, 0, 100);

    // reset in the middle of a long iteration
    do_reset();
    issue(0, 255, 1);
    run(6, 0, 100);
    do_reset();
    dut_grants.delete();
    log_grants = 1;
    issue(0, 10, 3);
    issue(2, 10, 3);
    run(30, 0, 100);
    log_grants = 0;
    chk("post_reset_grants", (dut_grants.size() >= 2), 1);
    if (dut_grants.size() >= 1) chk("post_reset_first", dut_grants[0], 0);

    // randomized traffic with random back-pressure
    run(4000, 30, 70);
    run(600, 0, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mod_arbiter.md
MOD_ARBITER -- requirements
Module: mod_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the engine.
REQ-002 Parameter W, default 8, dividend and result width.
REQ-003 Parameter DW, default 5, divisor width.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_ready  out  NREQ  one-hot accept (grant); at most one bit high per cycle.
REQ-008 req_value  in  NREQ*W  packed dividends; requester i at bits [i*W +: W].
REQ-009 req_div  in  NREQ*DW  packed divisors; requester i at bits [i*DW +: DW].
REQ-010 resp_valid  out  1  result available.
REQ-011 resp_ready  in  1  consumer accepts result.
REQ-012 resp_id  out  clog2(NREQ)  index of the requester that owns the result.
REQ-013 resp_rem  out  W  remainder value mod div.
REQ-014 resp_quo  out  W  quotient (see Configuration).
REQ-015 resp_err  out  1  divisor was zero.

Function
REQ-016 The FSM has states IDLE, ITER and DONE.
REQ-017 In IDLE, req_ready is the one-hot round-robin winner among asserted req_valid bits, and is 0 in ITER and DONE.
REQ-018 Round-robin priority starts at last_grant+1 and wraps from NREQ-1 to 0.
REQ-019 On the accept edge, the block latches value, div and id, loads acc=value and quo=0, updates last_grant, and moves to ITER.
REQ-020 Each ITER cycle with acc>=div, acc<=acc-div and quo<=quo+1, one subtraction per cycle.
REQ-021 The ITER cycle with acc<div moves to DONE; the accept-edge-to-resp_valid latency is q+1 cycles, where q = value/div.
REQ-022 If div==0, the next edge moves to DONE with resp_rem=value, resp_quo=all ones, resp_err=1; latency is 1 cycle.
REQ-023 In DONE, resp_valid=1 and resp_id/resp_rem/resp_quo/resp_err are stable until resp_valid&&resp_ready.
REQ-024 A resp_valid&&resp_ready handshake returns the FSM to IDLE; the earliest next grant is in the cycle after the handshake.
REQ-025 Requester inputs are ignored outside the accept edge; a requester may change value/div after acceptance.
REQ-026 Arithmetic: acc is W bits, div is zero-extended to W bits, and the comparison is unsigned.
REQ-027 A requester holding req_valid keeps its request pending; no request is dropped, and a requester waits at most NREQ-1 grants.
REQ-028 A value of 0 with nonzero div returns rem=0, quo=0 with latency 1.

Reset
REQ-029 Reset returns the FSM to IDLE from any state, abandoning any in-flight operation without a response.
REQ-030 Reset drives req_ready=0, resp_valid=0, resp_id=0, resp_rem=0, resp_quo=0, resp_err=0, acc=0, quo=0 and last_grant=NREQ-1, so requester 0 wins first.

Configuration
REQ-031 Macro MOD_ARBITER_QUOTIENT_EN compiles in the quotient counter.
REQ-032 With MOD_ARBITER_QUOTIENT_EN defined, resp_quo carries the quotient per REQ-020/REQ-022.
REQ-033 Without MOD_ARBITER_QUOTIENT_EN, the quo register is absent and resp_quo is constant 0 (including the div==0 case); the port and all timing are unchanged.

Structure
REQ-034 A shared package holds the FSM state enum (IDLE/ITER/DONE), default widths W/DW/NREQ and the ID-width function.
REQ-035 The round-robin grant logic is sub-module rr_arbiter (inputs: req vector, last_grant; output: one-hot grant); the subtract loop stays in mod_arbiter.

Verification
REQ-036 Reset, then requester 0 sends value=23, div=5 -> resp_valid 5 cycles after accept, with resp_rem=3, resp_quo=4, resp_id=0, resp_err=0.
REQ-037 All four requesters hold req_valid continuously with resp_ready=1 -> grants go 0,1,2,3,0 and each req_ready is one-hot.
REQ-038 Requester 2 sends value=200, div=0 -> 1 cycle later resp_rem=200, resp_quo=255, resp_err=1, resp_id=2.
REQ-039 value=9, div=7, resp_ready held 0 for 3 cycles -> resp_valid with rem=2, quo=1 stays stable all 3 cycles and no new req_ready is issued.
REQ-040 Reset asserted mid-ITER (value=255, div=1) -> the next cycle shows IDLE, resp_valid=0 and no response is emitted; requester 0 is granted first afterwards.
REQ-041 Build without MOD_ARBITER_QUOTIENT_EN and rerun REQ-036 -> rem=3, resp_quo=0, identical latency.
